// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store master.
// Optional misaligned-access trap is enabled with LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    size_bytes = 4'd1;
      2'd1:    size_bytes = 4'd2;
      2'd2:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

  // Loads reject 3'b111; stores only have the four signed encodings.
  function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
    f3_legal = write ? !funct3[2] : (funct3 != 3'b111);
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of an assembled little-endian load buffer by funct3.
// Also used by the register writeback mux.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] buf_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  always_comb begin
    data_o = buf_i;
    case (funct3_i)
      F3_B:    data_o = {{56{buf_i[7]}},  buf_i[7:0]};
      F3_H:    data_o = {{48{buf_i[15]}}, buf_i[15:0]};
      F3_W:    data_o = {{32{buf_i[31]}}, buf_i[31:0]};
      F3_BU:   data_o = {56'd0, buf_i[7:0]};
      F3_HU:   data_o = {48'd0, buf_i[15:0]};
      F3_WU:   data_o = {32'd0, buf_i[31:0]};
      default: data_o = buf_i;
    endcase
  end

endmodule

// File: rtl/lsu_byte_master.sv
// Serialises one load/store into 1/2/4/8 byte accesses, lowest address first.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned requests instead of serving them.
module lsu_byte_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [63:0]       buf_q, buf_d;
  logic              write_q, write_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              zero_q, zero_d;

  logic [3:0]  req_n, req_nm1, cur_nm1;
  logic        req_legal, req_misalign, req_skip, last_byte;
  logic [63:0] ext_data;

  assign req_n     = size_bytes(req_funct3);
  assign req_nm1   = req_n - 4'd1;
  assign req_legal = f3_legal(req_write, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misalign = |(req_addr[2:0] & req_nm1[2:0]);
`else
  assign req_misalign = 1'b0;
`endif
  assign req_skip  = !req_legal || req_misalign;
  assign cur_nm1   = size_bytes(f3_q) - 4'd1;
  assign last_byte = ({1'b0, k_q} == cur_nm1);

  lsu_load_extend u_ext (
    .buf_i    (buf_q),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_skip ? DONE : ACCESS;
      ACCESS:  if (last_byte) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_d     = k_q;
    buf_d   = buf_q;
    write_d = write_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          k_d     = '0;
          buf_d   = '0;
          err_d   = req_legal && req_misalign;
          zero_d  = req_write || req_skip;
        end
      end
      ACCESS: begin
        k_d = k_q + 3'd1;
        if (!write_q) buf_d[{k_q, 3'b000} +: 8] = mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= '0;
      buf_q   <= '0;
      write_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      k_q     <= k_d;
      buf_q   <= buf_d;
      write_q <= write_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs are masked while reset is high so an interrupted store commits no further byte.
  always_comb begin
    req_ready = 1'b0;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (reset) begin
      req_ready = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready = 1'b1;
          stall     = req_valid;
        end
        ACCESS: begin
          stall    = 1'b1;
          mem_addr = addr_q + ADDR_W'(k_q);
          mem_we   = write_q;
          mem_re   = !write_q;
          if (write_q) mem_wdata = wdata_q[{k_q, 3'b000} +: 8];
        end
        DONE: begin
          rsp_valid = 1'b1;
          rsp_rdata = zero_q ? '0 : XLEN'(ext_data);
          rsp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Randomised and directed bench for lsu_byte_master against a request-level memory model.
// Build with LSU_MISALIGN_TRAP_EN to exercise the misaligned-trap variant.
module tb_lsu_byte_master;

  localparam int W = 73;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic        load_mem;

  logic [7:0]   tb_mem    [256];
  logic [7:0]   model_mem [256];
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  lsu_byte_master #(.ADDR_W(64), .XLEN(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  // Device memory: 256 bytes aliased on the low address byte.
  assign mem_rdata = mem_re ? tb_mem[mem_addr[7:0]] : 8'h00;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= model_mem[i];
    end else if (mem_we) begin
      tb_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr);
    int          n;
    logic [63:0] raw;
    n   = 1 << f3[1:0];
    raw = '0;
    for (int i = 0; i < n; i++) raw |= 64'(model_mem[8'(addr + 64'(i))]) << (8 * i);
    if (n < 8 && !f3[2] && raw[8 * n - 1]) raw |= ~((64'd1 << (8 * n)) - 64'd1);
    return raw;
  endfunction

  task automatic scramble(input logic keep_valid);
    req_valid  = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
    req_write  = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom);
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
  endtask

  task automatic step_idle();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("idle_ready", req_ready, 1);
    check("idle_stall", stall, 0);
    check("idle_rsp",   rsp_valid, 0);
    check("idle_mem",   {mem_we, mem_re}, 0);
    @(posedge clk);
  endtask

  task automatic mem_check(input string tag);
    int bad;
    #1;
    bad = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== model_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic keep_valid,
                         output logic [63:0] rdata_obs, output logic err_obs);
    int           n, acc;
    logic         legal, trap;
    logic [63:0]  exp_rd;
    logic [W-1:0] e;
    n     = 1 << f3[1:0];
    legal = w ? !f3[2] : (f3 != 3'b111);
    trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap  = legal && ((addr % 64'(n)) != 64'd0);
`endif
    acc    = (legal && !trap) ? n : 0;
    exp_rd = (!w && acc > 0) ? model_load(f3, addr) : 64'd0;
    for (int i = 0; i < acc; i++)
      exp_q.push_back({w, addr + 64'(i), w ? wdata[8 * i +: 8] : 8'h00});
    if (w) for (int i = 0; i < acc; i++) model_mem[8'(addr + 64'(i))] = wdata[8 * i +: 8];

    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
    check("acc_req_ready", req_ready, 1);
    check("acc_req_stall", stall, 1);
    @(posedge clk);
    for (int i = 0; i < acc; i++) begin
      @(negedge clk);
      scramble(keep_valid);
      #1;
      e = exp_q.pop_front();
      check("byte_addr", mem_addr, e[71:8]);
      check("byte_we",   mem_we, e[72]);
      check("byte_re",   mem_re, !e[72]);
      if (e[72]) check("byte_wdata", mem_wdata, e[7:0]);
      check("byte_stall", stall, 1);
      check("byte_ready", req_ready, 0);
      check("byte_rsp",   rsp_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    scramble(keep_valid);
    #1;
    check("done_valid", rsp_valid, 1);
    check("done_stall", stall, 0);
    check("done_ready", req_ready, 0);
    check("done_mem",   {mem_we, mem_re}, 0);
    check("done_err",   rsp_err, trap);
    check("done_rdata", rsp_rdata, exp_rd);
    rdata_obs = rsp_rdata;
    err_obs   = rsp_err;
    @(posedge clk);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [7:0]  old6, old7;

    reset = 1'b1;
    load_mem = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'($urandom);
    model_mem[3] = 8'h80;
    model_mem[8] = 8'h64;
    for (int i = 9; i < 16; i++) model_mem[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_outs", {stall, rsp_valid, rsp_err, mem_we, mem_re}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rdata", rsp_rdata, 0);
    reset = 1'b0;
    load_mem = 1'b0;
    @(posedge clk);
    step_idle();

    run_req(1'b0, 3'b011, 64'd8, 64'd0, 1'b0, rd, er);
    check("ld8_value", rd, 64'h0000_0000_0000_0064);
    run_req(1'b1, 3'b011, 64'd16, 64'h0123_4567_89AB_CDEF, 1'b0, rd, er);
    check("sd16_rdata", rd, 64'd0);
    mem_check("sd16_mem");
    run_req(1'b0, 3'b011, 64'd16, 64'd0, 1'b0, rd, er);
    check("ld16_value", rd, 64'h0123_4567_89AB_CDEF);
    run_req(1'b0, 3'b000, 64'd3, 64'd0, 1'b0, rd, er);
    check("lb3_value", rd, 64'hFFFF_FFFF_FFFF_FF80);
    run_req(1'b0, 3'b100, 64'd3, 64'd0, 1'b0, rd, er);
    check("lbu3_value", rd, 64'h0000_0000_0000_0080);

    // Store interrupted by reset in its third byte cycle.
    old6 = model_mem[6];
    old7 = model_mem[7];
    model_mem[4] = 8'hDD;
    model_mem[5] = 8'hCC;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 64'd4; req_wdata = 64'hAABB_CCDD;
    #1;
    check("sw_rst_accept", req_ready, 1);
    @(posedge clk);
    @(negedge clk); scramble(1'b0); #1;
    check("sw_rst_b0", {mem_we, mem_addr, mem_wdata}, {1'b1, 64'd4, 8'hDD});
    @(posedge clk);
    @(negedge clk); scramble(1'b0); #1;
    check("sw_rst_b1", {mem_we, mem_addr, mem_wdata}, {1'b1, 64'd5, 8'hCC});
    @(posedge clk);
    @(negedge clk); reset = 1'b1; req_valid = 1'b0; #1;
    check("sw_rst_we", mem_we, 0);
    check("sw_rst_rdy", req_ready, 1);
    @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    check("sw_rst_after_ready", req_ready, 1);
    check("sw_rst_after_rsp",   rsp_valid, 0);
    check("sw_rst_after_stall", stall, 0);
    @(posedge clk);
    mem_check("sw_rst_mem");
    check("sw_rst_b6", tb_mem[6], old6);
    check("sw_rst_b7", tb_mem[7], old7);

    // Back-to-back loads with req_valid held high.
    run_req(1'b0, 3'b010, 64'd32, 64'd0, 1'b1, rd, er);
    run_req(1'b0, 3'b010, 64'd36, 64'd0, 1'b0, rd, er);

    run_req(1'b0, 3'b010, 64'd2, 64'd0, 1'b0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw2_err", er, 1);
    check("lw2_rdata", rd, 0);
`else
    check("lw2_err", er, 0);
    check("lw2_rdata", rd, model_load(3'b010, 64'd2));
`endif

    run_req(1'b0, 3'b111, 64'd40, 64'd0, 1'b0, rd, er);
    check("ill_ld_err", er, 0);
    run_req(1'b1, 3'b100, 64'd40, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, er);
    check("ill_st_err", er, 0);
    mem_check("ill_st_mem");

    run_req(1'b1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1122_3344, 1'b0, rd, er);
    run_req(1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0, rd, er);
    mem_check("wrap_mem");

    for (int t = 0; t < 120; t++) begin
      logic [63:0] a;
      a = {($urandom_range(0, 3) == 0) ? 56'hFF_FFFF_FFFF_FFFF : 56'd0, 8'($urandom)};
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
              {$urandom, $urandom}, 1'($urandom_range(0, 1)), rd, er);
      if ($urandom_range(0, 3) == 0) step_idle();
      if (t % 20 == 19) mem_check("rand_mem");
    end
    step_idle();
    check("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
